// File: rtl/exe_trace_capture.sv
// exe_trace_capture
//   Trace tap on the execution unit. Every cycle that trace_en and exe_enable
//   are both high, the retiring {PC_in, IR_in} pair goes into a 16-deep record
//   FIFO. A serializer drains the FIFO as 9-byte frames on a valid/ready byte
//   stream that feeds the UART TX path. Each frame is SYNC_BYTE, then PC
//   MSB-first, then IR MSB-first.
//
// Ports
//   clk, reset_n         core clock, synchronous active-low reset
//   trace_en             capture enable (0 = ignore exe_enable)
//   clear                synchronous flush of FIFO, serializer and statistics
//   exe_enable           retire strobe from the execution unit
//   PC_in, IR_in         PC / IR of the retiring instruction
//   byte_out/byte_valid  serialized byte stream (held until byte_ready)
//   byte_ready           consumer accepts byte_out this cycle
//   fifo_count           records currently buffered
//   overflow             sticky flag: a record was dropped since reset/clear
//   drop_count           dropped-record counter, saturating at 16'hFFFF
module exe_trace_capture #(
    parameter int unsigned FIFO_DEPTH_LOG2 = 4,
    parameter logic [7:0]  SYNC_BYTE       = 8'hA5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     trace_en,
    input  logic                     clear,
    input  logic                     exe_enable,
    input  logic [31:0]              PC_in,
    input  logic [31:0]              IR_in,
    output logic [7:0]               byte_out,
    output logic                     byte_valid,
    input  logic                     byte_ready,
    output logic [FIFO_DEPTH_LOG2:0] fifo_count,
    output logic                     overflow,
    output logic [15:0]              drop_count
);

    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned PW    = FIFO_DEPTH_LOG2 + 1;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    logic [63:0]                mem_q [DEPTH];
    logic [PW-1:0]              wr_cnt_q, wr_cnt_d;
    logic [PW-1:0]              rd_cnt_q, rd_cnt_d;
    logic [PW-1:0]              count;
    logic [FIFO_DEPTH_LOG2-1:0] wr_addr, rd_addr;

    state_t      state_q;
    logic [63:0] shift_q;
    logic [3:0]  idx_q;
    logic [7:0]  byte_q;
    logic        valid_q;
    logic        overflow_q;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    logic empty, full, last_accept, pop, push_req, push, drop;

    always_comb begin
        count   = wr_cnt_q - rd_cnt_q;
        wr_addr = wr_cnt_q[FIFO_DEPTH_LOG2-1:0];
        rd_addr = rd_cnt_q[FIFO_DEPTH_LOG2-1:0];
        empty   = (count == '0);
        // count never exceeds DEPTH, so its MSB alone marks the full state
        full    = count[FIFO_DEPTH_LOG2];

        // Last byte of a frame is being handed off this cycle
        last_accept = (state_q == SEND) && byte_ready && (idx_q == 4'd8);
        pop         = !empty && ((state_q == IDLE) || last_accept);

        push_req = trace_en & exe_enable;
        // A full FIFO still takes the record when a slot frees this same cycle
        push     = push_req && (!full || pop);
        drop     = push_req && !push;

        wr_cnt_d = push ? wr_cnt_q + PW'(1) : wr_cnt_q;
        rd_cnt_d = pop  ? rd_cnt_q + PW'(1) : rd_cnt_q;

        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Record storage needs no reset: pointers define which entries are live
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_addr] <= {PC_in, IR_in};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            state_q    <= IDLE;
            shift_q    <= '0;
            idx_q      <= '0;
            byte_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            if (drop) begin
                overflow_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (pop) begin
                        shift_q <= mem_q[rd_addr];
                        byte_q  <= SYNC_BYTE;
                        valid_q <= 1'b1;
                        idx_q   <= '0;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (byte_ready) begin
                        if (idx_q != 4'd8) begin
                            byte_q  <= shift_q[63:56];
                            shift_q <= {shift_q[55:0], 8'h00};
                            idx_q   <= idx_q + 4'd1;
                        end else if (pop) begin
                            // Next frame starts immediately, no idle cycle
                            shift_q <= mem_q[rd_addr];
                            byte_q  <= SYNC_BYTE;
                            idx_q   <= '0;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign byte_out   = byte_q;
    assign byte_valid = valid_q;
    assign fifo_count = count;
    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;

endmodule
